// File: rtl/alu_share_arbiter_if.sv
// Client request/response and shared-ALU signal bundle for alu_share_arbiter.
// slave = arbiter side, master = clients plus ALU side.
interface alu_share_arbiter_if #(
  parameter int N = 32
);
  logic         req_valid_0;
  logic         req_valid_1;
  logic         req_ready_0;
  logic         req_ready_1;
  logic [N-1:0] req_a_0;
  logic [N-1:0] req_a_1;
  logic [N-1:0] req_b_0;
  logic [N-1:0] req_b_1;
  logic [3:0]   req_op_0;
  logic [3:0]   req_op_1;
  logic         rsp_valid_0;
  logic         rsp_valid_1;
  logic         rsp_ready_0;
  logic         rsp_ready_1;
  logic [N-1:0] rsp_result;
  logic         rsp_zero;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_ctrl;
  logic [N-1:0] alu_result;
  logic         alu_zero;

  modport slave (
    input  req_valid_0, req_valid_1,
    output req_ready_0, req_ready_1,
    input  req_a_0, req_a_1,
    input  req_b_0, req_b_1,
    input  req_op_0, req_op_1,
    output rsp_valid_0, rsp_valid_1,
    input  rsp_ready_0, rsp_ready_1,
    output rsp_result, rsp_zero,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result, alu_zero
  );

  modport master (
    output req_valid_0, req_valid_1,
    input  req_ready_0, req_ready_1,
    output req_a_0, req_a_1,
    output req_b_0, req_b_1,
    output req_op_0, req_op_1,
    input  rsp_valid_0, rsp_valid_1,
    output rsp_ready_0, rsp_ready_1,
    input  rsp_result, rsp_zero,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result, alu_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-client arbiter/sequencer for one shared ALU (IDLE -> EXEC -> RESP).
// ALU_ARB_FIXED_PRIO_EN: client 0 always wins; default is round-robin.
module alu_share_arbiter #(
  parameter int N = 32
) (
  input logic               clk,
  input logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e       state_q, state_d;
  logic         owner_q, owner_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [3:0]   op_q, op_d;
  logic [N-1:0] res_q, res_d;
  logic         zero_q, zero_d;
  logic         gnt_0, gnt_1;
  logic         done;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_0 = bus.req_valid_0;
    gnt_1 = bus.req_valid_1 & ~bus.req_valid_0;
  end
`else
  logic ptr_q, ptr_d;

  // ptr only matters on contention; a lone valid always wins
  always_comb begin
    gnt_0 = bus.req_valid_0 & (~bus.req_valid_1 | ~ptr_q);
    gnt_1 = bus.req_valid_1 & (~bus.req_valid_0 | ptr_q);
  end
`endif

  assign done = owner_q ? bus.rsp_ready_1 : bus.rsp_ready_0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_0 | gnt_1) begin
          owner_d = gnt_1;
          a_d     = gnt_1 ? bus.req_a_1 : bus.req_a_0;
          b_d     = gnt_1 ? bus.req_b_1 : bus.req_b_0;
          op_d    = gnt_1 ? bus.req_op_1 : bus.req_op_0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = bus.alu_result;
        zero_d  = bus.alu_zero;
        state_d = RESP;
      end
      RESP: begin
        if (done) begin
          state_d = IDLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
          ptr_d   = ~owner_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.req_ready_0 = rst_n & (state_q == IDLE) & gnt_0;
  assign bus.req_ready_1 = rst_n & (state_q == IDLE) & gnt_1;
  assign bus.rsp_valid_0 = (state_q == RESP) & ~owner_q;
  assign bus.rsp_valid_1 = (state_q == RESP) & owner_q;
  assign bus.rsp_result  = res_q;
  assign bus.rsp_zero    = zero_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_ctrl    = op_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the shared port.
// Define ALU_ARB_FIXED_PRIO_EN for both DUT and bench to check fixed priority.
module tb_alu_share_arbiter;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  alu_share_arbiter_if #(.N(32)) bus ();

  alu_share_arbiter #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] alu_r;
  always_comb begin
    alu_r = 32'd0;
    case (bus.alu_ctrl)
      4'b0000: alu_r = bus.alu_a & bus.alu_b;
      4'b0001: alu_r = bus.alu_a | bus.alu_b;
      4'b0010: alu_r = bus.alu_a + bus.alu_b;
      4'b0110: alu_r = bus.alu_a - bus.alu_b;
      4'b0111: alu_r = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      4'b1100: alu_r = ~(bus.alu_a | bus.alu_b);
      default: alu_r = 32'd0;
    endcase
    bus.alu_result = alu_r;
    bus.alu_zero   = (alu_r == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  initial begin
    int g;
    errs   = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.req_valid_0 = 1'b1;
    bus.req_valid_1 = 1'b1;
    bus.req_a_0  = 32'd4;
    bus.req_b_0  = 32'd5;
    bus.req_op_0 = 4'b0010;
    bus.req_a_1  = 32'd4;
    bus.req_b_1  = 32'd5;
    bus.req_op_1 = 4'b0000;
    bus.rsp_ready_0 = 1'b0;
    bus.rsp_ready_1 = 1'b0;

    // reset with both valids high
    repeat (3) tick();
    chk("rst_rdy0", {31'd0, bus.req_ready_0}, 32'd0);
    chk("rst_rdy1", {31'd0, bus.req_ready_1}, 32'd0);
    chk("rst_rv0", {31'd0, bus.rsp_valid_0}, 32'd0);
    chk("rst_rv1", {31'd0, bus.rsp_valid_1}, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    chk("rst_res", bus.rsp_result, 32'd0);
    chk("rst_zero", {31'd0, bus.rsp_zero}, 32'd0);

    rst_n = 1'b1;
    #1;
    chk("rel_rdy0", {31'd0, bus.req_ready_0}, 32'd1);
    chk("rel_rdy1", {31'd0, bus.req_ready_1}, 32'd0);

    // single ADD 4+5 from client 0; client 1 drops its valid
    tick();
    bus.req_valid_0 = 1'b0;
    bus.req_valid_1 = 1'b0;
    bus.rsp_ready_0 = 1'b1;
    #1;
    chk("ex_rdy0", {31'd0, bus.req_ready_0}, 32'd0);
    chk("ex_rv0", {31'd0, bus.rsp_valid_0}, 32'd0);
    chk("ex_alu_a", bus.alu_a, 32'd4);
    chk("ex_alu_b", bus.alu_b, 32'd5);
    chk("ex_ctrl", {28'd0, bus.alu_ctrl}, 32'd2);
    tick();
    chk("add_rv0", {31'd0, bus.rsp_valid_0}, 32'd1);
    chk("add_rv1", {31'd0, bus.rsp_valid_1}, 32'd0);
    chk("add_res", bus.rsp_result, 32'd9);
    chk("add_zero", {31'd0, bus.rsp_zero}, 32'd0);
    tick();
    chk("add_done", {31'd0, bus.rsp_valid_0}, 32'd0);
    chk("drop_rdy1", {31'd0, bus.req_ready_1}, 32'd0);

    // contention: SUB 5-5 on client 0, AND 4&5 on client 1
    bus.req_a_0  = 32'd5;
    bus.req_b_0  = 32'd5;
    bus.req_op_0 = 4'b0110;
    bus.req_valid_0 = 1'b1;
    bus.req_valid_1 = 1'b1;
    bus.rsp_ready_1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = (k % 2 == 0) ? 1 : 0;
`endif
      #1;
      chk("ct_rdy0", {31'd0, bus.req_ready_0}, (g == 0) ? 32'd1 : 32'd0);
      chk("ct_rdy1", {31'd0, bus.req_ready_1}, (g == 1) ? 32'd1 : 32'd0);
      tick();
      chk("ct_ctrl", {28'd0, bus.alu_ctrl}, (g == 1) ? 32'd0 : 32'd6);
      tick();
      chk("ct_rv0", {31'd0, bus.rsp_valid_0}, (g == 0) ? 32'd1 : 32'd0);
      chk("ct_rv1", {31'd0, bus.rsp_valid_1}, (g == 1) ? 32'd1 : 32'd0);
      chk("ct_res", bus.rsp_result, (g == 1) ? 32'd4 : 32'd0);
      chk("ct_zero", {31'd0, bus.rsp_zero}, (g == 1) ? 32'd0 : 32'd1);
      tick();
    end

    // backpressure on client 1: ADD 7+3 held for 10 cycles
    bus.req_valid_0 = 1'b0;
    bus.req_a_1  = 32'd7;
    bus.req_b_1  = 32'd3;
    bus.req_op_1 = 4'b0010;
    bus.rsp_ready_1 = 1'b0;
    #1;
    chk("bp_rdy1", {31'd0, bus.req_ready_1}, 32'd1);
    tick();
    bus.req_valid_1 = 1'b0;
    bus.req_valid_0 = 1'b1;
    #1;
    chk("bp_ex_rdy0", {31'd0, bus.req_ready_0}, 32'd0);
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("bp_rv1", {31'd0, bus.rsp_valid_1}, 32'd1);
      chk("bp_rv0", {31'd0, bus.rsp_valid_0}, 32'd0);
      chk("bp_res", bus.rsp_result, 32'd10);
      chk("bp_alu_a", bus.alu_a, 32'd7);
      chk("bp_ctrl", {28'd0, bus.alu_ctrl}, 32'd2);
      chk("bp_rdy0", {31'd0, bus.req_ready_0}, 32'd0);
      tick();
    end
    bus.rsp_ready_1 = 1'b1;
    tick();
    chk("bp_done", {31'd0, bus.rsp_valid_1}, 32'd0);
    chk("bp_nxt_rdy0", {31'd0, bus.req_ready_0}, 32'd1);

    // accept client 0, then reset during EXEC
    tick();
    bus.req_valid_0 = 1'b0;
    #1;
    rst_n = 1'b0;
    #2;
    chk("mr_rv0", {31'd0, bus.rsp_valid_0}, 32'd0);
    chk("mr_alu_a", bus.alu_a, 32'd0);
    chk("mr_res", bus.rsp_result, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_quiet0", {31'd0, bus.rsp_valid_0}, 32'd0);
      chk("mr_quiet1", {31'd0, bus.rsp_valid_1}, 32'd0);
    end

    // next request after abort: OR 12|3 on client 0
    bus.req_a_0  = 32'd12;
    bus.req_b_0  = 32'd3;
    bus.req_op_0 = 4'b0001;
    bus.req_valid_0 = 1'b1;
    #1;
    chk("pr_rdy0", {31'd0, bus.req_ready_0}, 32'd1);
    tick();
    bus.req_valid_0 = 1'b0;
    tick();
    chk("pr_rv0", {31'd0, bus.rsp_valid_0}, 32'd1);
    chk("pr_res", bus.rsp_result, 32'd15);
    chk("pr_zero", {31'd0, bus.rsp_zero}, 32'd0);
    tick();
    chk("pr_done", {31'd0, bus.rsp_valid_0}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU in the RISC-V datapath. It accepts operation requests (operands plus 4-bit ALU control) from two independent clients over valid/ready handshakes. It grants one request at a time, drives the shared ALU from registered operands, captures `ALUResult`/`zero`, and returns them to the granted client over a response handshake. It sits between the clients, such as the main execute path and an address/branch-compare helper, and a single ALU instance.

## Interface
- `N`, default 32: operand/result width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid_0` / `req_valid_1`  in  1  request valid, per client.
- `req_ready_0` / `req_ready_1`  out  1  request accepted this cycle when high together with the matching valid.
- `req_a_0` / `req_a_1`  in  N  operand A, per client.
- `req_b_0` / `req_b_1`  in  N  operand B, per client.
- `req_op_0` / `req_op_1`  in  4  ALU control code, per client.
- `rsp_valid_0` / `rsp_valid_1`  out  1  response valid, per client.
- `rsp_ready_0` / `rsp_ready_1`  in  1  client accepts response.
- `rsp_result`  out  N  captured ALU result, shared by both clients.
- `rsp_zero`  out  1  captured ALU zero flag.
- `alu_a`, `alu_b`  out  N  drive ALU `A`/`B`.
- `alu_ctrl`  out  4  drives ALU `ALUcontrol_in`.
- `alu_result`  in  N  from ALU `ALUResult`.
- `alu_zero`  in  1  from ALU `zero`.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - Grant is combinational from the valids and the priority pointer `ptr` (reset 0). Only a requester with valid high can be granted.
  - If both valids are high, client `ptr` wins. If only one is high, that client wins.
  - `req_ready_g` is high only for the granted client `g`, and only in IDLE.
  - On handshake, latch `a`, `b`, `op` and owner `g` into internal registers, then go to EXEC.
- **EXEC**
  - `alu_a`/`alu_b`/`alu_ctrl` drive the latched values; the ALU is combinational.
  - On the closing edge, capture `alu_result`→`rsp_result` and `alu_zero`→`rsp_zero`, then go to RESP.
- **RESP**
  - `rsp_valid_g` is high for the owner only.
  - Hold RESP, with result and ALU drive unchanged, until `rsp_ready_g` is high. Then go to IDLE and set `ptr` to the other client.
- Client rules: clients must hold `req_*` stable while valid is high and unaccepted. A dropped valid is never granted retroactively.
- `alu_ctrl` codes are passed through unmodified; the arbiter never interprets them.
- `alu_a`/`alu_b`/`alu_ctrl` retain their last latched values in IDLE; they change only on acceptance.

## Timing
- Reset (`rst_n` low, asynchronous) sets:
  - state IDLE and `ptr`=0;
  - `alu_a`=`alu_b`=0 and `alu_ctrl`=0;
  - `rsp_result`=0 and `rsp_zero`=0;
  - both `rsp_valid` low and both `req_ready` low (gated by `rst_n`).
- Latency: request accepted in cycle T; EXEC in T+1; `rsp_valid` high from T+2. If `rsp_ready` is already high at T+2, the block is back in IDLE at T+3.
- Peak throughput is one operation per 3 cycles. No request is accepted while in EXEC or RESP.
- Response stall: both `req_ready` stay low indefinitely while RESP waits on `rsp_ready`.
- Reset asserted in EXEC or RESP aborts the operation; no response is ever issued for it.
- Simultaneous requests plus `ptr`: back-to-back contention alternates 0,1,0,1. A lone requester is granted every slot regardless of `ptr`.
- `rsp_ready` high for the non-owning client is ignored.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: fixed priority. Client 0 always wins contention; `ptr` is not implemented.
- Macro undefined (default): round-robin as described in Operation.

## Test plan
- **Reset:** hold `rst_n` low with both valids high → all outputs 0, both `req_ready` low. Release → client 0 granted in the first cycle.
- **Single request:** client 0, A=4, B=5, op=0010 (ADD) → `rsp_valid_0` two cycles after acceptance, `rsp_result`=9, `rsp_zero`=0.
- **Contention:** both valid every cycle, client 0 op 0110 (SUB) 5−5, client 1 op 0000 (AND) 4&5 → grants alternate 0,1,0,1. Results 0 with zero=1, and 4 with zero=0.
- **Backpressure:** hold `rsp_ready_1` low for 10 cycles → `rsp_valid_1`, `rsp_result` and `alu_*` stay stable, and `req_ready_0` stays low throughout.
- **Mid-op reset:** pulse `rst_n` low during EXEC → no `rsp_valid` is seen; the next request completes normally.
- **Fixed priority:** with `ALU_ARB_FIXED_PRIO_EN` and both valid continuously → client 0 is granted every slot.
